xmodem_loader: RTL and testbench
================================

Name: xmodem_loader

Overview:
Hardware XMODEM (checksum variant) receiver that loads a program image sent over the UART. It writes the image word-by-word into instruction/boot memory, the write side of the same memory and XMODEM transfer the boot code reports on. It sits between the UART byte receiver/transmitter and the memory write port. It signals `done` or `error` to the boot control logic.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- MEM_BYTES, 8192, writable region size in bytes; a block that would exceed it aborts the transfer.
- NAK_INTERVAL, 50_000_000, clock cycles between idle NAKs and the inter-byte timeout.
- MAX_RETRY, 10, consecutive NAKs allowed before abort.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, one-cycle pulse; begins a transfer from IDLE/DONE/ERR; ignored otherwise.
- rx_valid, input, 1, one-cycle strobe: rx_data holds a received byte.
- rx_data, input, 8, received byte.
- tx_valid, output, 1, response byte valid; held until tx_ready.
- tx_data, output, 8, response byte (ACK 0x06, NAK 0x15, CAN 0x18).
- tx_ready, input, 1, UART transmitter accepts byte when tx_valid & tx_ready.
- wr_en, output, 1, one-cycle memory write strobe.
- wr_addr, output, 32, word-aligned byte address.
- wr_data, output, 32, little-endian word (first byte in [7:0]).
- busy, output, 1, high in all states except IDLE/DONE/ERR.
- done, output, 1, sticky high after EOT acknowledged; cleared by start.
- error, output, 1, sticky high after abort; cleared by start.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, all outputs 0, expected block = 1, retry = 0, timer = 0. Reset mid-transfer abandons it with no further writes or tx bytes.
- Protocol constants: SOH 0x01, EOT 0x04.
- States: IDLE, SEND_NAK, WAIT_SOH, BLK, NBLK, DATA, CSUM, RESP, DONE_ACK, DONE, CANCEL, ERR.
- IDLE/DONE/ERR + start: clear done/error/retry, expected block = 1, go to SEND_NAK.
- SEND_NAK: tx_valid=1, tx_data=0x15; on handshake go to WAIT_SOH and restart timer.
- WAIT_SOH:
  - rx SOH → BLK.
  - rx EOT → DONE_ACK.
  - rx 0x18 → ERR.
  - Any other byte ignored.
  - Timer reaching NAK_INTERVAL → retry+1, then SEND_NAK; if retry would exceed MAX_RETRY → CANCEL.
- BLK: store blk byte. NBLK: header_ok = (nblk == ~blk).
- Block classification:
  - blk == expected & header_ok → "new": writes enabled.
  - blk == expected-1 (mod 256) & header_ok → "duplicate": writes suppressed, ACK sent.
  - Otherwise → "bad": writes suppressed, NAK sent.
- DATA: accept exactly 128 bytes.
  - Byte offset 0..127; running 8-bit sum of the data bytes.
  - Each byte shifts into a word assembler.
  - The cycle after byte offset%4==3 is accepted, if writes are enabled: wr_en=1 for one cycle, wr_addr = BASE_ADDR + (expected-1)*128 + (offset & ~3), wr_data = assembled word.
  - The 8-bit expected counter wraps; the address uses a full 32-bit block index.
  - If (expected)*128 > MEM_BYTES for a new block → CANCEL before any write of that block.
- CSUM: the checksum byte is compared with the sum.
  - Mismatch on a new block: the words already written stay; the retransmission overwrites the same addresses.
- RESP:
  - New block & checksum OK: ACK, expected+1, retry=0.
  - Duplicate block & checksum OK: ACK, expected unchanged.
  - Otherwise: NAK with retry+1; → CANCEL if retry > MAX_RETRY.
  - After the handshake go to WAIT_SOH.
- Inter-byte timeout in BLK/NBLK/DATA/CSUM: timer hits NAK_INTERVAL without rx_valid → discard block, retry+1, then SEND_NAK (or CANCEL).
- rx_valid while tx_valid is pending (RESP/SEND_NAK): byte dropped.
- DONE_ACK: send ACK, then DONE (done=1).
- CANCEL: send CAN once, then ERR (error=1).
- tx_data stable while tx_valid=1; tx_valid deasserts the cycle after the handshake.
- wr_en never asserted outside DATA/CSUM entry.

Test Plan:
- Single block: start, tx_ready=1 → expect NAK. Send SOH,01,FE, bytes 0x00..0x7F, checksum 0xC0 → 32 writes, first wr_addr=BASE_ADDR with wr_data=0x03020100, last wr_addr=BASE_ADDR+0x7C with wr_data=0x7F7E7D7C; tx ACK. Then EOT → ACK, done=1, busy=0.
- Bad checksum: same block with checksum 0xC1 → NAK, retry=1. Retransmit with 0xC0 → ACK, same addresses rewritten, next block written at BASE_ADDR+0x80.
- Duplicate: after block 1 ACKed, resend block 1 → ACK, zero wr_en pulses, block 2 still lands at BASE_ADDR+0x80.
- Header error: SOH,01,FD + 129 bytes → NAK, no writes. Block 3 when expecting 2 → NAK, no writes.
- Timeout/retry: NAK_INTERVAL=100, no input → NAK every ~100 cycles; after MAX_RETRY+1 attempts tx CAN, error=1.
- Reset mid-DATA and start while busy: rst_n=0 after 10 data bytes → all outputs 0, IDLE, no further wr_en. start pulse during DATA → ignored, transfer completes normally.

Source files
------------

// File: rtl/xmodem_loader.sv
// XMODEM (checksum variant) receiver that streams a program image into
// boot memory one little-endian word at a time, answering the sender with
// ACK/NAK/CAN and flagging done/error to boot control.
module xmodem_loader #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MEM_BYTES    = 8192,
  parameter int          NAK_INTERVAL = 50_000_000,
  parameter int          MAX_RETRY    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EOT = 8'h04;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] CAN = 8'h18;

  localparam logic [31:0] TIMER_LAST  = 32'(NAK_INTERVAL - 1);
  localparam logic [31:0] RETRY_LIMIT = 32'(MAX_RETRY);
  localparam logic [39:0] MEM_LIMIT   = 40'(MEM_BYTES);

  typedef enum logic [3:0] {
    IDLE,
    SEND_NAK,
    WAIT_SOH,
    BLK,
    NBLK,
    DATA,
    CSUM,
    RESP,
    DONE_ACK,
    DONE,
    CANCEL,
    ERR
  } state_t;

  state_t state, state_next;

  // Block bookkeeping: expected is the 8-bit on-wire block number, blk_idx
  // is the full-width count of accepted blocks used for addressing.
  logic [7:0]  expected;
  logic [31:0] blk_idx;
  logic [7:0]  blk_num;
  logic [7:0]  retry;
  logic [31:0] timer;
  logic [6:0]  offset;
  logic [7:0]  sum;
  logic [23:0] word;
  logic        blk_new;
  logic        blk_dup;
  logic        resp_ack;
  logic        resp_advance;
  logic        done_r;
  logic        error_r;
  logic        wr_en_r;
  logic [31:0] wr_addr_r;
  logic [31:0] wr_data_r;

  logic        timer_active;
  logic        timeout;
  logic        retry_exhausted;
  logic        header_ok;
  logic        hdr_new;
  logic        hdr_dup;
  logic [39:0] blk_end;
  logic        mem_overflow;
  logic        csum_ok;
  logic        start_ok;
  logic        rx_take;

  assign timer_active    = (state == WAIT_SOH) || (state == BLK) || (state == NBLK) ||
                           (state == DATA) || (state == CSUM);
  assign rx_take         = rx_valid && timer_active;
  assign timeout         = timer_active && !rx_valid && (timer == TIMER_LAST);
  assign retry_exhausted = (({24'd0, retry} + 32'd1) > RETRY_LIMIT);
  assign header_ok       = (rx_data == ~blk_num);
  assign hdr_new         = header_ok && (blk_num == expected);
  assign hdr_dup         = header_ok && (blk_num == (expected - 8'd1));
  assign blk_end         = ({8'd0, blk_idx} + 40'd1) << 7;
  assign mem_overflow    = (blk_end > MEM_LIMIT);
  assign csum_ok         = (rx_data == sum);
  assign start_ok        = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and the UART response byte, which is a pure function
  // of state so it stays stable for as long as tx_valid is held.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_next = SEND_NAK;
      end
      SEND_NAK: begin
        tx_valid = 1'b1;
        tx_data  = NAK;
        if (tx_ready) state_next = WAIT_SOH;
      end
      WAIT_SOH: begin
        if (rx_valid) begin
          if (rx_data == SOH)      state_next = BLK;
          else if (rx_data == EOT) state_next = DONE_ACK;
          else if (rx_data == CAN) state_next = ERR;
        end else if (timeout) begin
          state_next = retry_exhausted ? CANCEL : SEND_NAK;
        end
      end
      BLK: begin
        if (rx_valid)     state_next = NBLK;
        else if (timeout) state_next = retry_exhausted ? CANCEL : SEND_NAK;
      end
      NBLK: begin
        if (rx_valid)     state_next = (hdr_new && mem_overflow) ? CANCEL : DATA;
        else if (timeout) state_next = retry_exhausted ? CANCEL : SEND_NAK;
      end
      DATA: begin
        if (rx_valid) begin
          if (offset == 7'd127) state_next = CSUM;
        end else if (timeout) begin
          state_next = retry_exhausted ? CANCEL : SEND_NAK;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if ((csum_ok && (blk_new || blk_dup)) || !retry_exhausted) state_next = RESP;
          else                                                       state_next = CANCEL;
        end else if (timeout) begin
          state_next = retry_exhausted ? CANCEL : SEND_NAK;
        end
      end
      RESP: begin
        tx_valid = 1'b1;
        tx_data  = resp_ack ? ACK : NAK;
        if (tx_ready) state_next = WAIT_SOH;
      end
      DONE_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK;
        if (tx_ready) state_next = DONE;
      end
      CANCEL: begin
        tx_valid = 1'b1;
        tx_data  = CAN;
        if (tx_ready) state_next = ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Inter-byte / idle timer: restarts on every state change and every
  // accepted byte, counts only while waiting on the sender.
  always_ff @(posedge clk) begin
    if (!rst_n)                                             timer <= 32'd0;
    else if ((state_next != state) || rx_take || !timer_active) timer <= 32'd0;
    else                                                    timer <= timer + 32'd1;
  end

  // Block datapath: header capture, word assembly, checksum, memory writes,
  // retry accounting and the sticky done/error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      expected     <= 8'd1;
      blk_idx      <= 32'd0;
      blk_num      <= 8'd0;
      retry        <= 8'd0;
      offset       <= 7'd0;
      sum          <= 8'd0;
      word         <= 24'd0;
      blk_new      <= 1'b0;
      blk_dup      <= 1'b0;
      resp_ack     <= 1'b0;
      resp_advance <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= 32'd0;
      wr_data_r    <= 32'd0;
    end else begin
      wr_en_r <= 1'b0;
      if (start_ok) begin
        done_r   <= 1'b0;
        error_r  <= 1'b0;
        retry    <= 8'd0;
        expected <= 8'd1;
        blk_idx  <= 32'd0;
      end
      if (timeout && !retry_exhausted) retry <= retry + 8'd1;
      case (state)
        WAIT_SOH: begin
          if (rx_valid && (rx_data == CAN)) error_r <= 1'b1;
        end
        BLK: begin
          if (rx_valid) blk_num <= rx_data;
        end
        NBLK: begin
          if (rx_valid) begin
            blk_new <= hdr_new;
            blk_dup <= hdr_dup;
            offset  <= 7'd0;
            sum     <= 8'd0;
          end
        end
        DATA: begin
          if (rx_valid) begin
            word   <= {rx_data, word[23:8]};
            sum    <= sum + rx_data;
            offset <= offset + 7'd1;
            if ((offset[1:0] == 2'd3) && blk_new) begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= BASE_ADDR + {blk_idx[24:0], 7'd0} + {25'd0, offset[6:2], 2'd0};
              wr_data_r <= {rx_data, word};
            end
          end
        end
        CSUM: begin
          if (rx_valid) begin
            resp_ack     <= csum_ok && (blk_new || blk_dup);
            resp_advance <= csum_ok && blk_new;
          end
        end
        RESP: begin
          if (tx_ready) begin
            if (resp_advance) begin
              expected <= expected + 8'd1;
              blk_idx  <= blk_idx + 32'd1;
              retry    <= 8'd0;
            end else if (!resp_ack) begin
              retry <= retry + 8'd1;
            end
          end
        end
        DONE_ACK: begin
          if (tx_ready) done_r <= 1'b1;
        end
        CANCEL: begin
          if (tx_ready) error_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign done    = done_r;
  assign error   = error_r;
  assign busy    = !((state == IDLE) || (state == DONE) || (state == ERR));

endmodule

// File: tb/tb_xmodem_loader.sv
// Directed bench for xmodem_loader: drives XMODEM blocks byte by byte and
// checks responses, memory writes and status flags against hand values.
module tb_xmodem_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [7:0]  SOH  = 8'h01;
  localparam logic [7:0]  EOT  = 8'h04;
  localparam logic [7:0]  ACK  = 8'h06;
  localparam logic [7:0]  NAK  = 8'h15;
  localparam logic [7:0]  CAN  = 8'h18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail = 0;
  int wr_count = 0;
  int tx_count = 0;
  logic [31:0] wr_addr_log [0:1023];
  logic [31:0] wr_data_log [0:1023];
  logic [7:0]  tx_log [0:1023];

  xmodem_loader #(
    .BASE_ADDR(BASE),
    .MEM_BYTES(256),
    .NAK_INTERVAL(100),
    .MAX_RETRY(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  // Log every memory write and every completed tx handshake.
  always @(posedge clk) begin
    if (wr_en) begin
      wr_addr_log[wr_count % 1024] = wr_addr;
      wr_data_log[wr_count % 1024] = wr_data;
      wr_count = wr_count + 1;
    end
    if (tx_valid && tx_ready) begin
      tx_log[tx_count % 1024] = tx_data;
      tx_count = tx_count + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] blk, input logic [7:0] nblk,
                            input logic [7:0] first, input logic [7:0] csum);
    send_byte(SOH);
    send_byte(blk);
    send_byte(nblk);
    for (int i = 0; i < 128; i++) send_byte(8'(first + i));
    send_byte(csum);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tx(input int base, output logic [7:0] b, output bit got);
    got = 1'b0;
    b   = 8'h00;
    for (int i = 0; i < 60; i++) begin
      if (tx_count > base) begin
        got = 1'b1;
        b   = tx_log[base % 1024];
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({tx_valid, wr_en, busy, done, error} !== 5'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b/%h expected 00000/00",
               {tx_valid, wr_en, busy, done, error}, tx_data);
    end
    n_checks++;
    if (wr_addr !== 32'd0 || wr_data !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_wr_bus: got %h/%h expected 0/0", wr_addr, wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    int tb; int wb; logic [7:0] b; bit got;
    tx_ready = 1'b0;
    tb = tx_count;
    pulse_start();
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== NAK || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL nak_held: got v=%b d=%h busy=%b expected 1/15/1", tx_valid, tx_data, busy);
    end
    tx_ready = 1'b1;
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== NAK) begin
      n_fail++;
      $display("[TB] FAIL first_nak: got %h (seen=%0d) expected 15", b, got);
    end
    wb = wr_count;
    tb = tx_count;
    send_block(8'h01, 8'hFE, 8'h00, 8'hC0);
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== ACK) begin
      n_fail++;
      $display("[TB] FAIL single_ack: got %h (seen=%0d) expected 06", b, got);
    end
    n_checks++;
    if (wr_count - wb !== 32) begin
      n_fail++;
      $display("[TB] FAIL single_wr_count: got %0d expected 32", wr_count - wb);
    end
    n_checks++;
    if (wr_addr_log[wb % 1024] !== BASE || wr_data_log[wb % 1024] !== 32'h03020100) begin
      n_fail++;
      $display("[TB] FAIL single_first_word: got %h=%h expected %h=03020100",
               wr_addr_log[wb % 1024], wr_data_log[wb % 1024], BASE);
    end
    n_checks++;
    if (wr_addr_log[(wb + 31) % 1024] !== BASE + 32'h7C ||
        wr_data_log[(wb + 31) % 1024] !== 32'h7F7E7D7C) begin
      n_fail++;
      $display("[TB] FAIL single_last_word: got %h=%h expected %h=7f7e7d7c",
               wr_addr_log[(wb + 31) % 1024], wr_data_log[(wb + 31) % 1024], BASE + 32'h7C);
    end
    tb = tx_count;
    send_byte(EOT);
    wait_tx(tb, b, got);
    @(negedge clk);
    n_checks++;
    if (!got || b !== ACK || done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL eot_done: got tx=%h done=%b busy=%b err=%b expected 06/1/0/0",
               b, done, busy, error);
    end
  endtask

  task automatic test_bad_checksum();
    int tb; int wb; logic [7:0] b; bit got;
    tb = tx_count;
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL restart_clears_done: got done=%b busy=%b expected 0/1", done, busy);
    end
    wait_tx(tb, b, got);
    wb = wr_count;
    tb = tx_count;
    send_block(8'h01, 8'hFE, 8'h00, 8'hC1);
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== NAK || wr_count - wb !== 32) begin
      n_fail++;
      $display("[TB] FAIL bad_csum_nak: got tx=%h writes=%0d expected 15/32", b, wr_count - wb);
    end
    wb = wr_count;
    tb = tx_count;
    send_block(8'h01, 8'hFE, 8'h00, 8'hC0);
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== ACK || wr_count - wb !== 32 ||
        wr_addr_log[wb % 1024] !== BASE || wr_data_log[wb % 1024] !== 32'h03020100) begin
      n_fail++;
      $display("[TB] FAIL retransmit_ack: got tx=%h writes=%0d first=%h expected 06/32/%h",
               b, wr_count - wb, wr_addr_log[wb % 1024], BASE);
    end
    wb = wr_count;
    tb = tx_count;
    send_block(8'h02, 8'hFD, 8'h80, 8'hC0);
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== ACK || wr_count - wb !== 32 ||
        wr_addr_log[wb % 1024] !== BASE + 32'h80 || wr_data_log[wb % 1024] !== 32'h83828180) begin
      n_fail++;
      $display("[TB] FAIL block2_addr: got tx=%h writes=%0d %h=%h expected 06/32/%h=83828180",
               b, wr_count - wb, wr_addr_log[wb % 1024], wr_data_log[wb % 1024], BASE + 32'h80);
    end
  endtask

  task automatic test_duplicate_and_headers();
    int tb; int wb; logic [7:0] b; bit got;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tb = tx_count;
    pulse_start();
    wait_tx(tb, b, got);
    tb = tx_count;
    send_block(8'h01, 8'hFE, 8'h00, 8'hC0);
    wait_tx(tb, b, got);
    wb = wr_count;
    tb = tx_count;
    send_block(8'h01, 8'hFE, 8'h00, 8'hC0);
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== ACK || wr_count - wb !== 0) begin
      n_fail++;
      $display("[TB] FAIL duplicate_ack: got tx=%h writes=%0d expected 06/0", b, wr_count - wb);
    end
    wb = wr_count;
    tb = tx_count;
    send_block(8'h01, 8'hFD, 8'h00, 8'hC0);
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== NAK || wr_count - wb !== 0) begin
      n_fail++;
      $display("[TB] FAIL bad_header_nak: got tx=%h writes=%0d expected 15/0", b, wr_count - wb);
    end
    wb = wr_count;
    tb = tx_count;
    send_block(8'h03, 8'hFC, 8'h00, 8'hC0);
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== NAK || wr_count - wb !== 0) begin
      n_fail++;
      $display("[TB] FAIL wrong_block_nak: got tx=%h writes=%0d expected 15/0", b, wr_count - wb);
    end
    wb = wr_count;
    tb = tx_count;
    send_block(8'h02, 8'hFD, 8'h80, 8'hC0);
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== ACK || wr_count - wb !== 32 || wr_addr_log[wb % 1024] !== BASE + 32'h80) begin
      n_fail++;
      $display("[TB] FAIL block2_after_dup: got tx=%h writes=%0d addr=%h expected 06/32/%h",
               b, wr_count - wb, wr_addr_log[wb % 1024], BASE + 32'h80);
    end
    // A third block would run past the 256-byte region.
    wb = wr_count;
    tb = tx_count;
    send_block(8'h03, 8'hFC, 8'h00, 8'hC0);
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== CAN || wr_count - wb !== 0 || error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mem_overflow_can: got tx=%h writes=%0d err=%b busy=%b expected 18/0/1/0",
               b, wr_count - wb, error, busy);
    end
  endtask

  task automatic test_timeout();
    int tb; int naks; bit finished;
    tb = tx_count;
    naks = 0;
    finished = 1'b0;
    pulse_start();
    for (int i = 0; i < 1400; i++) begin
      if (error === 1'b1) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    for (int i = tb; i < tx_count; i++) if (tx_log[i % 1024] === NAK) naks++;
    n_checks++;
    if (!finished || naks !== 11 || tx_count - tb !== 12 || tx_log[(tx_count - 1) % 1024] !== CAN) begin
      n_fail++;
      $display("[TB] FAIL retry_cancel: got naks=%0d bytes=%0d last=%h err=%b expected 11/12/18/1",
               naks, tx_count - tb, tx_log[(tx_count - 1) % 1024], finished);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL retry_idle_flags: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_reset_mid_data();
    int tb; int wb; logic [7:0] b; bit got;
    tb = tx_count;
    pulse_start();
    wait_tx(tb, b, got);
    wb = wr_count;
    send_byte(SOH);
    send_byte(8'h01);
    send_byte(8'hFE);
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    n_checks++;
    if (wr_count - wb !== 2 || wr_data_log[(wb + 1) % 1024] !== 32'h07060504) begin
      n_fail++;
      $display("[TB] FAIL partial_writes: got %0d last=%h expected 2/07060504",
               wr_count - wb, wr_data_log[(wb + 1) % 1024]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tx_valid, wr_en, busy, done, error} !== 5'b0 || wr_addr !== 32'd0 || wr_data !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_outputs: got %b %h %h expected 00000 0 0",
               {tx_valid, wr_en, busy, done, error}, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    wb = wr_count;
    tb = tx_count;
    for (int i = 10; i < 128; i++) send_byte(8'(i));
    send_byte(8'hC0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (wr_count - wb !== 0 || tx_count - tb !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL after_reset_quiet: got writes=%0d tx=%0d busy=%b expected 0/0/0",
               wr_count - wb, tx_count - tb, busy);
    end
  endtask

  task automatic test_back_to_back();
    int tb; int wb; logic [7:0] b; bit got;
    tb = tx_count;
    pulse_start();
    wait_tx(tb, b, got);
    wb = wr_count;
    tb = tx_count;
    send_byte(SOH);
    send_byte(8'h01);
    send_byte(8'hFE);
    for (int i = 0; i < 50; i++) send_byte(8'(i));
    pulse_start();
    for (int i = 50; i < 128; i++) send_byte(8'(i));
    send_byte(8'hC0);
    wait_tx(tb, b, got);
    n_checks++;
    if (!got || b !== ACK || wr_count - wb !== 32 || busy !== 1'b1 ||
        wr_data_log[(wb + 12) % 1024] !== 32'h33323130) begin
      n_fail++;
      $display("[TB] FAIL start_ignored: got tx=%h writes=%0d busy=%b w12=%h expected 06/32/1/33323130",
               b, wr_count - wb, busy, wr_data_log[(wb + 12) % 1024]);
    end
    tb = tx_count;
    send_byte(EOT);
    wait_tx(tb, b, got);
    @(negedge clk);
    n_checks++;
    if (!got || b !== ACK || done !== 1'b1 || tx_count - tb !== 1) begin
      n_fail++;
      $display("[TB] FAIL b2b_done: got tx=%h done=%b bytes=%0d expected 06/1/1", b, done, tx_count - tb);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_block();
    test_bad_checksum();
    test_duplicate_and_headers();
    test_timeout();
    test_reset_mid_data();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so a stuck handshake can never hang the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
